mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single DPI-backed physical memory port between instruction fetch (IF) and the load/store unit (LS) of the NPC core. It accepts one request at a time from either requester over a valid/ready handshake and sequences the transaction on the memory side. The read data or write acknowledge is returned to the requester that issued it. The block sits between the fetch/LSU stages and the memory wrapper that calls pmem_read/pmem_write.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 32, data width; write-mask width is DATA_W/8

Ports:
clk  input  1  core clock, all state updates on posedge
rst  input  1  asynchronous reset, active-low (asserted when 0)
if_valid  input  1  fetch request valid (read only)
if_ready  output  1  fetch request accepted this cycle
if_addr  input  ADDR_W  fetch address (pc)
if_rvalid  output  1  one-cycle pulse: fetch data valid
if_rdata  output  DATA_W  fetched instruction word
ls_valid  input  1  LSU request valid
ls_ready  output  1  LSU request accepted this cycle
ls_addr  input  ADDR_W  LSU address
ls_wen  input  1  1 = store, 0 = load
ls_wdata  input  DATA_W  store data
ls_wmask  input  DATA_W/8  store byte mask
ls_rvalid  output  1  one-cycle pulse: load data / store ack
ls_rdata  output  DATA_W  load data
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  memory address
mem_wen  output  1  memory write enable
mem_wdata  output  DATA_W  memory write data
mem_wmask  output  DATA_W/8  memory byte mask
mem_rvalid  input  1  memory response valid (read data or write ack)
mem_rdata  input  DATA_W  memory read data
arb_busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. At most one outstanding transaction.
- IDLE:
  - Grant is combinational. If ls_valid, then ls_ready=1 and if_ready=0 (LS has fixed priority). Otherwise if_ready=if_valid.
  - Both ready outputs are 0 in every state other than IDLE.
- Accept (valid & ready): latch addr, wen, wdata, wmask and owner into registers, then go to REQ. An IF request latches wen=0 and wmask=0.
- REQ:
  - mem_valid=1; mem_addr, mem_wen, mem_wdata and mem_wmask are driven from the latched registers.
  - These outputs stay stable until mem_valid & mem_ready; then go to WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT: on mem_rvalid, capture mem_rdata into rdata_q and go to RESP. mem_rvalid is sampled only in this state.
- RESP:
  - The owner's rvalid is 1 for exactly one cycle; its rdata = rdata_q. Then return to IDLE.
  - Requesters cannot back-pressure responses.
- rdata outputs hold rdata_q at all times (both ports). For a store, ls_rvalid is the write ack and ls_rdata = the captured mem_rdata (don't-care).
- Minimum latency: accept in cycle N → mem_valid in N+1. With mem_ready=1 in N+1 and mem_rvalid=1 in N+2, rvalid is seen in N+3.
- A new request can be accepted in the IDLE cycle directly after RESP; there is no back-to-back accept in RESP.
- Simultaneous valids in IDLE: LS wins. IF must hold if_valid and if_addr until if_ready.
- Requester valid dropping before ready: no effect; nothing is latched.
- Reset (rst=0, asynchronous), all of the following take effect immediately:
  - state=IDLE; mem_valid, if_rvalid, ls_rvalid and arb_busy all 0.
  - All latched registers and rdata_q = 0.
  - A reset mid-transaction abandons it; no response is delivered.
- arb_busy is a registered decode of state: 1 in REQ, WAIT and RESP.

Optional Feature:
ARB_RR_EN:
- Defined: tie in IDLE grants the requester not served most recently. A last_owner register is updated on each accept and resets to IF, so the first tie after reset grants LS. A single valid requester is always granted.
- Undefined: fixed LS priority as above; last_owner logic is absent.

Test Plan:
- Reset: hold rst=0 mid-REQ with mem_valid=1 → mem_valid, if_rvalid, ls_rvalid and arb_busy drop to 0 in the same cycle, without waiting for clk. After release, IF read 0x80000000 completes normally.
- IF read: if_valid, if_addr=0x80000000 in cycle 0; mem_ready=1 in cycle 1; mem_rvalid=1, mem_rdata=0x00000413 in cycle 2 → if_rvalid=1, if_rdata=0x00000413 in cycle 3 only; ls_rvalid stays 0.
- Store with stall: ls_wen=1, ls_addr=0x80000100, ls_wdata=0xDEADBEEF, ls_wmask=0xF; mem_ready held 0 for 3 cycles → mem_valid stays 1 with addr/data/mask unchanged. After mem_ready and mem_rvalid → single ls_rvalid pulse.
- Tie (macro off): if_valid (0x80000004) and ls_valid (0x80001000, load) both asserted → LS is accepted first. IF is accepted in the IDLE cycle after ls_rvalid, and mem_addr=0x80000004 for the second transaction.
- Spurious response: mem_rvalid=1 during REQ → ignored, no rvalid out. The transaction completes only on mem_rvalid in WAIT.
- ARB_RR_EN: both requesters continuously valid, memory zero-wait → grant order LS, IF, LS, IF. With the macro off, the same stimulus gives LS, LS, LS, LS.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester (IF, LS) and memory-side handshake bundle for mem_arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_valid;
   logic              if_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic                ls_valid;
   logic                ls_ready;
   logic [ADDR_W-1:0]   ls_addr;
   logic                ls_wen;
   logic [DATA_W-1:0]   ls_wdata;
   logic [DATA_W/8-1:0] ls_wmask;
   logic                ls_rvalid;
   logic [DATA_W-1:0]   ls_rdata;

   logic                mem_valid;
   logic                mem_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_wen;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W/8-1:0] mem_wmask;
   logic                mem_rvalid;
   logic [DATA_W-1:0]   mem_rdata;

   modport slave (
      input  if_valid, if_addr,
      output if_ready, if_rvalid, if_rdata,
      input  ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
      output ls_ready, ls_rvalid, ls_rdata,
      output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport master (
      output if_valid, if_addr,
      input  if_ready, if_rvalid, if_rdata,
      output ls_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
      input  ls_ready, ls_rvalid, ls_rdata,
      input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (IF) and LSU (LS).
// Optional ARB_RR_EN: ties alternate via last_owner; otherwise LS has fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_if.slave    bus,
   output logic            arb_busy
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wmask_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                busy_q;
   logic                grant_if, grant_ls;

`ifdef ARB_RR_EN
   owner_t last_owner_q;

   // On a tie, LS wins only if IF was served most recently.
   always_comb begin
      grant_ls = bus.ls_valid & (~bus.if_valid | (last_owner_q == OWN_IF));
      grant_if = bus.if_valid & ~grant_ls;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_owner_q <= OWN_IF;
      else if (state_q == IDLE && (grant_ls || grant_if))
         last_owner_q <= grant_ls ? OWN_LS : OWN_IF;
   end
`else
   always_comb begin
      grant_ls = bus.ls_valid;
      grant_if = bus.if_valid & ~bus.ls_valid;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.if_ready  = 1'b0;
      bus.ls_ready  = 1'b0;
      bus.mem_valid = 1'b0;
      bus.if_rvalid = 1'b0;
      bus.ls_rvalid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.ls_ready = grant_ls;
            bus.if_ready = grant_if;
            if (grant_ls || grant_if)
               state_d = REQ;
         end
         REQ: begin
            bus.mem_valid = 1'b1;
            if (bus.mem_ready)
               state_d = WAIT;
         end
         WAIT: begin
            if (bus.mem_rvalid)
               state_d = RESP;
         end
         RESP: begin
            bus.if_rvalid = (owner_q == OWN_IF);
            bus.ls_rvalid = (owner_q == OWN_LS);
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q <= OWN_IF;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (state_q == IDLE) begin
         if (grant_ls) begin
            owner_q <= OWN_LS;
            addr_q  <= bus.ls_addr;
            wen_q   <= bus.ls_wen;
            wdata_q <= bus.ls_wdata;
            wmask_q <= bus.ls_wmask;
         end else if (grant_if) begin
            owner_q <= OWN_IF;
            addr_q  <= bus.if_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rdata_q <= '0;
      else if (state_q == WAIT && bus.mem_rvalid)
         rdata_q <= bus.mem_rdata;
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wen   = wen_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wmask = wmask_q;
   assign bus.if_rdata  = rdata_q;
   assign bus.ls_rdata  = rdata_q;
   assign arb_busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, IF read, tie, store stall, spurious response, grant order.
// Inputs change on negedge; outputs are checked #1 later, away from the posedge.
module tb_mem_arbiter;
   logic clk;
   logic rst;
   logic busy;
   int   n_cmp;
   int   n_err;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .arb_busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic if_read(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.if_valid = 1'b1; bus.if_addr = a;
      #1 chk("if_rd_if_ready", {31'b0, bus.if_ready}, 32'd1);
      chk("if_rd_ls_ready", {31'b0, bus.ls_ready}, 32'd0);
      @(negedge clk);
      bus.if_valid = 1'b0; bus.if_addr = 32'hFFFF_FFFF; bus.mem_ready = 1'b1;
      #1 chk("if_rd_mem_valid", {31'b0, bus.mem_valid}, 32'd1);
      chk("if_rd_mem_addr", bus.mem_addr, a);
      chk("if_rd_mem_wen", {31'b0, bus.mem_wen}, 32'd0);
      chk("if_rd_mem_wmask", {28'b0, bus.mem_wmask}, 32'd0);
      chk("if_rd_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = d;
      #1 chk("if_rd_wait_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      chk("if_rd_wait_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'hBAD0_BAD0;
      #1 chk("if_rd_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
      chk("if_rd_if_rdata", bus.if_rdata, d);
      chk("if_rd_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
      @(negedge clk);
      #1 chk("if_rd_pulse_end", {31'b0, bus.if_rvalid}, 32'd0);
      chk("if_rd_idle_busy", {31'b0, busy}, 32'd0);
   endtask

   logic [1:0] grants [4];
   logic [1:0] exp_g  [4];
   int         n_g;

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b0;
      bus.if_valid = 1'b0; bus.if_addr = '0;
      bus.ls_valid = 1'b0; bus.ls_addr = '0; bus.ls_wen = 1'b0;
      bus.ls_wdata = '0; bus.ls_wmask = '0;
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

      // Reset state
      @(negedge clk); @(negedge clk);
      #1 chk("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
      chk("rst_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      @(negedge clk); rst = 1'b1;

      // Plain IF read
      if_read(32'h8000_0000, 32'h0000_0413);

      // Tie: LS load wins, IF holds; spurious mem_rvalid in REQ is ignored
      @(negedge clk);
      bus.if_valid = 1'b1; bus.if_addr = 32'h8000_0004;
      bus.ls_valid = 1'b1; bus.ls_addr = 32'h8000_1000; bus.ls_wen = 1'b0;
      #1 chk("tie_ls_ready", {31'b0, bus.ls_ready}, 32'd1);
      chk("tie_if_ready", {31'b0, bus.if_ready}, 32'd0);
      @(negedge clk);
      bus.ls_valid = 1'b0; bus.mem_ready = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_0001;
      #1 chk("tie_mem_addr_ls", bus.mem_addr, 32'h8000_1000);
      chk("tie_req_if_ready", {31'b0, bus.if_ready}, 32'd0);
      chk("spur_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b1;
      #1 chk("spur_still_req", {31'b0, bus.mem_valid}, 32'd1);
      chk("spur_no_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1 chk("tie_wait_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      chk("tie_wait_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1122_3344;
      #1 chk("tie_wait2_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #1 chk("tie_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd1);
      chk("tie_ls_rdata", bus.ls_rdata, 32'h1122_3344);
      chk("tie_resp_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
      chk("tie_resp_no_accept", {31'b0, bus.if_ready}, 32'd0);
      @(negedge clk);
      #1 chk("tie_if_accept", {31'b0, bus.if_ready}, 32'd1);
      @(negedge clk);
      bus.if_valid = 1'b0; bus.mem_ready = 1'b1;
      #1 chk("tie_mem_addr_if", bus.mem_addr, 32'h8000_0004);
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0055;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      #1 chk("tie_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
      chk("tie_if_rdata", bus.if_rdata, 32'h0000_0055);

      // Store with 3-cycle mem_ready stall; requester inputs change after accept
      @(negedge clk);
      bus.ls_valid = 1'b1; bus.ls_wen = 1'b1; bus.ls_addr = 32'h8000_0100;
      bus.ls_wdata = 32'hDEAD_BEEF; bus.ls_wmask = 4'hF;
      #1 chk("st_ls_ready", {31'b0, bus.ls_ready}, 32'd1);
      @(negedge clk);
      bus.ls_valid = 1'b0; bus.ls_wdata = 32'h0; bus.ls_addr = 32'h0; bus.ls_wmask = 4'h0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("st_stall_valid", {31'b0, bus.mem_valid}, 32'd1);
         chk("st_stall_addr", bus.mem_addr, 32'h8000_0100);
         chk("st_stall_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
         chk("st_stall_wmask", {28'b0, bus.mem_wmask}, 32'h0000_000F);
         chk("st_stall_wen", {31'b0, bus.mem_wen}, 32'd1);
         @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      #1 chk("st_req_valid", {31'b0, bus.mem_valid}, 32'd1);
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
      @(negedge clk);
      bus.mem_rvalid = 1'b0; bus.ls_wen = 1'b0;
      #1 chk("st_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd1);
      chk("st_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
      @(negedge clk);
      #1 chk("st_pulse_end", {31'b0, bus.ls_rvalid}, 32'd0);

      // IF after a masked store must drive wen=0, wmask=0
      if_read(32'h8000_0008, 32'hCAFE_F00D);

      // Asynchronous reset in the middle of REQ
      @(negedge clk);
      bus.if_valid = 1'b1; bus.if_addr = 32'h8000_0000;
      @(negedge clk);
      bus.if_valid = 1'b0; bus.mem_ready = 1'b0;
      #1 chk("mid_pre_mem_valid", {31'b0, bus.mem_valid}, 32'd1);
      #1 rst = 1'b0;
      #1 chk("mid_rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
      chk("mid_rst_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
      chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      if_read(32'h8000_0000, 32'h0000_0413);

      // Grant order with both requesters always valid and zero-wait memory
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
      bus.if_valid = 1'b1; bus.if_addr = 32'h8000_0010;
      bus.ls_valid = 1'b1; bus.ls_addr = 32'h8000_2000; bus.ls_wen = 1'b0;
      n_g = 0;
      for (int c = 0; c < 24 && n_g < 4; c++) begin
         #1;
         if (bus.ls_ready || bus.if_ready) begin
            grants[n_g] = {bus.ls_ready, bus.if_ready};
            n_g++;
         end
         @(negedge clk);
      end
      bus.if_valid = 1'b0; bus.ls_valid = 1'b0;
`ifdef ARB_RR_EN
      exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`else
      exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
      chk("grant_count", n_g, 32'd4);
      for (int k = 0; k < 4; k++)
         if (k < n_g) chk("grant_order", {30'b0, grants[k]}, {30'b0, exp_g[k]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
